v_w_divider_scheduler: RTL and testbench
========================================

// Module: v_w_divider_scheduler
// PURPOSE
// Shares one pipelined V/W divider datapath (Z = V/W, C = |W| delay path) between NUM_SCALES per-scale streams.
// Round-robin arbitration with valid/ready on the scale side; one request issued per cycle into the divider.
// A scale tag rides a shift pipe matched to divider latency, so each returning result is steered to its scale.
// Sits between the per-scale V/W accumulators and the per-scale confidence/depth output stages.
// PARAMETERS
// EXP_WIDTH     8   exponent width of FP operands
// FRAC_WIDTH    23  fraction width of FP operands
// NUM_SCALES    3   number of requesting scales (>=2)
// DIV_LATENCY   8   cycles from divider valid_i to divider valid_o (must equal instantiated divider)
// FP_WIDTH_REG  1+EXP_WIDTH+FRAC_WIDTH (local)
// SCALE_W       $clog2(NUM_SCALES) (local)
// PORTS
// clk_i        in   1                   single clock, rising edge
// rst_i        in   1                   asynchronous reset, active-low; divider must share this reset
// enable_i     in   1                   0 = grant nothing (drain); in-flight work still completes
// v_i          in   NUM_SCALES*FP_WIDTH_REG  per-scale V, scale k at [k*FPW +: FPW]
// w_i          in   NUM_SCALES*FP_WIDTH_REG  per-scale W
// col_i        in   NUM_SCALES*16       per-scale column
// row_i        in   NUM_SCALES*16       per-scale row
// valid_i      in   NUM_SCALES          per-scale request valid
// ready_o      out  NUM_SCALES          one-hot grant; transfer when valid_i[k]&ready_o[k]
// div_v_o      out  FP_WIDTH_REG        to divider v_i
// div_w_o      out  FP_WIDTH_REG        to divider w_i
// div_col_o    out  16                  to divider col_i
// div_row_o    out  16                  to divider row_i
// div_valid_o  out  1                   to divider valid_i
// div_z_i      in   FP_WIDTH_REG        from divider z_o
// div_c_i      in   FP_WIDTH_REG        from divider c_o
// div_col_i    in   16                  from divider col_o
// div_row_i    in   16                  from divider row_o
// div_valid_i  in   1                   from divider valid_o
// z_o, c_o     out  FP_WIDTH_REG each   result, registered
// col_o, row_o out  16 each             result coordinates, registered
// scale_o      out  SCALE_W             scale index of current result
// valid_o      out  NUM_SCALES          one-hot result valid for scale scale_o
// inflight_o   out  $clog2(DIV_LATENCY+3)+1  accepted-but-not-output count
// idle_o       out  1                   inflight_o==0 && no valid_i granted this cycle
// err_o        out  1                   sticky: tag-pipe valid != div_valid_i
// BEHAVIOUR
// - Reset (rst_i=0, async): all registered outputs 0, tag pipe cleared, rr pointer = NUM_SCALES-1, err_o=0.
// - Arbitration (comb): if enable_i, grant first k with valid_i[k], searching from ptr+1 modulo NUM_SCALES.
//   ready_o = grant; never depends on ready_o itself. No valid or enable_i=0 -> ready_o=0, ptr holds.
// - On grant at edge t: ptr<=k; div_*_o <= scale k operands, div_valid_o<=1 at t+1; else div_valid_o<=0
//   (data regs hold). Tag pipe stage0 <= {1,k} aligned with div_valid_o.
// - Tag pipe: DIV_LATENCY stages, shifts every cycle (divider never stalls); last stage aligns with div_valid_i.
// - Return: when tag_last.valid, at next edge z_o/c_o/col_o/row_o <= div_*_i, scale_o<=tag.scale,
//   valid_o <= 1<<tag.scale; else valid_o<=0, data hold. No downstream backpressure.
// - Total latency accept->valid_o = DIV_LATENCY+2 cycles; throughput 1/cycle across all scales.
// - err_o: set when tag_last.valid != div_valid_i; stays 1 until reset; results still forwarded per tag.
// - inflight_o: +1 on accept, -1 on valid_o; both same cycle -> unchanged; max DIV_LATENCY+2.
// - enable_i low mid-stream: in-flight results drain normally; idle_o rises once inflight_o==0.
// - Reset mid-operation: in-flight results discarded (divider also reset); no spurious valid_o after release.
// - Single requester continuously valid gets every cycle; all valid -> strict rotation 0,1,2,0,...
// TESTING
// - Reset then scale1 alone: v=0x40800000(4.0), w=0x40000000(2.0) -> valid_o=3'b010, z_o=0x40000000, 10 cycles later.
// - All 3 scales valid 9 cycles -> grants 0,1,2,0,1,2,0,1,2; outputs in same order with matching col/row.
// - w=0xC0000000(-2.0) -> c_o=0x40000000 (sign cleared), z_o sign correct, scale tag preserved.
// - enable_i=0 while 5 in flight -> ready_o=0, 5 results emerge, idle_o=1, inflight_o=0.
// - Inject div_valid_i=1 with empty tag pipe -> err_o=1 next cycle, stays 1 until rst_i pulse.
// - Assert rst_i low with 6 in flight -> all outputs 0 immediately; no valid_o after release.

Source files
------------

// File: rtl/v_w_divider_scheduler_if.sv
// Bundle of the scale-side request/result signals and the divider-side signals
// for one shared V/W divider scheduler.
interface v_w_divider_scheduler_if #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int NUM_SCALES  = 3,
    parameter int DIV_LATENCY = 8
);
    localparam int FPW     = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int SCALE_W = $clog2(NUM_SCALES);
    localparam int INF_W   = $clog2(DIV_LATENCY + 3) + 1;

    logic                      enable_i;
    logic [NUM_SCALES*FPW-1:0] v_i;
    logic [NUM_SCALES*FPW-1:0] w_i;
    logic [NUM_SCALES*16-1:0]  col_i;
    logic [NUM_SCALES*16-1:0]  row_i;
    logic [NUM_SCALES-1:0]     valid_i;
    logic [NUM_SCALES-1:0]     ready_o;

    logic [FPW-1:0]            div_v_o;
    logic [FPW-1:0]            div_w_o;
    logic [15:0]               div_col_o;
    logic [15:0]               div_row_o;
    logic                      div_valid_o;
    logic [FPW-1:0]            div_z_i;
    logic [FPW-1:0]            div_c_i;
    logic [15:0]               div_col_i;
    logic [15:0]               div_row_i;
    logic                      div_valid_i;

    logic [FPW-1:0]            z_o;
    logic [FPW-1:0]            c_o;
    logic [15:0]               col_o;
    logic [15:0]               row_o;
    logic [SCALE_W-1:0]        scale_o;
    logic [NUM_SCALES-1:0]     valid_o;
    logic [INF_W-1:0]          inflight_o;
    logic                      idle_o;
    logic                      err_o;

    modport slave (
        input  enable_i, v_i, w_i, col_i, row_i, valid_i,
        input  div_z_i, div_c_i, div_col_i, div_row_i, div_valid_i,
        output ready_o, div_v_o, div_w_o, div_col_o, div_row_o, div_valid_o,
        output z_o, c_o, col_o, row_o, scale_o, valid_o, inflight_o, idle_o, err_o
    );

    modport master (
        output enable_i, v_i, w_i, col_i, row_i, valid_i,
        output div_z_i, div_c_i, div_col_i, div_row_i, div_valid_i,
        input  ready_o, div_v_o, div_w_o, div_col_o, div_row_o, div_valid_o,
        input  z_o, c_o, col_o, row_o, scale_o, valid_o, inflight_o, idle_o, err_o
    );
endinterface

// File: rtl/v_w_divider_scheduler.sv
// Round-robin scheduler sharing one fixed-latency V/W divider between NUM_SCALES
// streams; a scale tag travels beside the divider to steer each result home.
module v_w_divider_scheduler #(
    parameter int EXP_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 23,
    parameter int NUM_SCALES  = 3,
    parameter int DIV_LATENCY = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    v_w_divider_scheduler_if.slave bus
);
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int SCALE_W      = $clog2(NUM_SCALES);
    localparam int INF_W        = $clog2(DIV_LATENCY + 3) + 1;
    localparam logic [SCALE_W-1:0] LAST_SCALE = SCALE_W'(NUM_SCALES - 1);

    logic [SCALE_W-1:0]    ptr;
    logic [SCALE_W-1:0]    grant_idx;
    logic                  grant_any;
    int                    cand;

    // Tag entry 0 sits beside div_valid_o; entry DIV_LATENCY beside div_valid_i.
    logic [DIV_LATENCY:0]  tag_valid;
    logic [SCALE_W-1:0]    tag_scale [DIV_LATENCY+1];
    logic                  tag_last_valid;
    logic [SCALE_W-1:0]    tag_last_scale;

    // Handshake: a scale transfers in any cycle where valid_i[k] & ready_o[k];
    // ready_o is a pure function of enable_i, valid_i and the rr pointer.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (bus.enable_i) begin
            for (int i = 1; i <= NUM_SCALES; i++) begin
                cand = (int'(ptr) + i) % NUM_SCALES;
                if (!grant_any && bus.valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = SCALE_W'(cand);
                end
            end
        end
    end

    assign bus.ready_o    = grant_any ? (NUM_SCALES'(1) << grant_idx) : '0;
    assign tag_last_valid = tag_valid[DIV_LATENCY];
    assign tag_last_scale = tag_scale[DIV_LATENCY];
    assign bus.idle_o     = (bus.inflight_o == '0) && !grant_any;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr             <= LAST_SCALE;
            bus.div_v_o     <= '0;
            bus.div_w_o     <= '0;
            bus.div_col_o   <= '0;
            bus.div_row_o   <= '0;
            bus.div_valid_o <= 1'b0;
            tag_valid       <= '0;
            for (int i = 0; i <= DIV_LATENCY; i++) begin
                tag_scale[i] <= '0;
            end
            bus.z_o         <= '0;
            bus.c_o         <= '0;
            bus.col_o       <= '0;
            bus.row_o       <= '0;
            bus.scale_o     <= '0;
            bus.valid_o     <= '0;
            bus.inflight_o  <= '0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.div_valid_o <= grant_any;
            if (grant_any) begin
                ptr           <= grant_idx;
                bus.div_v_o   <= bus.v_i[int'(grant_idx)*FP_WIDTH_REG +: FP_WIDTH_REG];
                bus.div_w_o   <= bus.w_i[int'(grant_idx)*FP_WIDTH_REG +: FP_WIDTH_REG];
                bus.div_col_o <= bus.col_i[int'(grant_idx)*16 +: 16];
                bus.div_row_o <= bus.row_i[int'(grant_idx)*16 +: 16];
            end

            // The divider never stalls, so the tag pipe shifts unconditionally.
            tag_valid    <= {tag_valid[DIV_LATENCY-1:0], grant_any};
            tag_scale[0] <= grant_idx;
            for (int i = 1; i <= DIV_LATENCY; i++) begin
                tag_scale[i] <= tag_scale[i-1];
            end

            if (tag_last_valid) begin
                bus.z_o     <= bus.div_z_i;
                bus.c_o     <= bus.div_c_i;
                bus.col_o   <= bus.div_col_i;
                bus.row_o   <= bus.div_row_i;
                bus.scale_o <= tag_last_scale;
                bus.valid_o <= NUM_SCALES'(1) << tag_last_scale;
            end else begin
                bus.valid_o <= '0;
            end

            bus.inflight_o <= bus.inflight_o + INF_W'(grant_any) - INF_W'(|bus.valid_o);

            if (tag_last_valid != bus.div_valid_i) begin
                bus.err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_v_w_divider_scheduler.sv
// Self-checking bench for v_w_divider_scheduler: a fixed-latency divider stub,
// an arbitration/scoreboard reference model, directed tables and random traffic.
module tb_v_w_divider_scheduler;
    localparam int EXP_WIDTH  = 8;
    localparam int FRAC_WIDTH = 23;
    localparam int NS         = 3;
    localparam int LAT        = 8;
    localparam int FPW        = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int SW         = $clog2(NS);
    localparam int REC_W      = NS + SW + 2*FPW + 32;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic inject = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    v_w_divider_scheduler_if #(
        .EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH),
        .NUM_SCALES(NS), .DIV_LATENCY(LAT)
    ) bus ();

    v_w_divider_scheduler #(
        .EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH),
        .NUM_SCALES(NS), .DIV_LATENCY(LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- divider stub ----------------
    // Exponent-subtract divide: exact for operands with zero fraction.
    function automatic logic [FPW-1:0] div_model(input logic [FPW-1:0] v, input logic [FPW-1:0] w);
        logic [FPW-2:0] mag;
        mag = v[FPW-2:0] - w[FPW-2:0] + 31'h3F800000;
        return {v[FPW-1] ^ w[FPW-1], mag};
    endfunction

    logic [LAT-1:0] pv;
    logic [FPW-1:0] pz   [LAT];
    logic [FPW-1:0] pc   [LAT];
    logic [15:0]    pcol [LAT];
    logic [15:0]    prow [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < LAT; i++) begin
                pz[i] <= '0; pc[i] <= '0; pcol[i] <= '0; prow[i] <= '0;
            end
        end else begin
            pv      <= {pv[LAT-2:0], bus.div_valid_o};
            pz[0]   <= div_model(bus.div_v_o, bus.div_w_o);
            pc[0]   <= {1'b0, bus.div_w_o[FPW-2:0]};
            pcol[0] <= bus.div_col_o;
            prow[0] <= bus.div_row_o;
            for (int i = 1; i < LAT; i++) begin
                pz[i] <= pz[i-1]; pc[i] <= pc[i-1]; pcol[i] <= pcol[i-1]; prow[i] <= prow[i-1];
            end
        end
    end

    assign bus.div_valid_i = pv[LAT-1] | inject;
    assign bus.div_z_i     = pz[LAT-1];
    assign bus.div_c_i     = pc[LAT-1];
    assign bus.div_col_i   = pcol[LAT-1];
    assign bus.div_row_i   = prow[LAT-1];

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [REC_W-1:0] exp_q[$];
    int               acc_cyc_q[$];
    int               m_ptr   = NS - 1;
    int               acc_cnt = 0;
    int               out_cnt = 0;
    logic [NS-1:0]    exp_rdy;
    logic [NS-1:0]    acc;
    logic [REC_W-1:0] rec;
    int               lat;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_cyc_q.delete();
            m_ptr   = NS - 1;
            acc_cnt = 0;
            out_cnt = 0;
        end else begin
            exp_rdy = '0;
            if (bus.enable_i) begin
                for (int i = 1; i <= NS; i++) begin
                    if (exp_rdy == '0 && bus.valid_i[(m_ptr + i) % NS]) exp_rdy[(m_ptr + i) % NS] = 1'b1;
                end
            end
            check("mon_ready", 128'(bus.ready_o), 128'(exp_rdy));
            acc = bus.valid_i & exp_rdy;
            check("mon_inflight", 128'(bus.inflight_o), 128'(acc_cnt - out_cnt));
            check("mon_idle", 128'(bus.idle_o), 128'((acc_cnt == out_cnt) && (acc == '0)));

            for (int k = 0; k < NS; k++) begin
                if (acc[k]) begin
                    m_ptr = k;
                    exp_q.push_back({acc, SW'(k),
                                     div_model(bus.v_i[k*FPW +: FPW], bus.w_i[k*FPW +: FPW]),
                                     {1'b0, bus.w_i[k*FPW + FPW - 2 -: FPW - 1]},
                                     bus.col_i[k*16 +: 16], bus.row_i[k*16 +: 16]});
                    acc_cyc_q.push_back(cyc);
                    acc_cnt++;
                end
            end

            if (bus.valid_o != '0) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid_o=%b expected no result (cycle %0d)", bus.valid_o, cyc);
                end else begin
                    rec = exp_q.pop_front();
                    lat = cyc - acc_cyc_q.pop_front();
                    check("mon_result", 128'({bus.valid_o, bus.scale_o, bus.z_o, bus.c_o, bus.col_o, bus.row_o}), 128'(rec));
                    check("mon_latency", 128'(lat), 128'(LAT + 2));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scale(input int k, input logic [FPW-1:0] v, input logic [FPW-1:0] w,
                             input logic [15:0] col, input logic [15:0] row);
        bus.v_i[k*FPW +: FPW] = v;
        bus.w_i[k*FPW +: FPW] = w;
        bus.col_i[k*16 +: 16] = col;
        bus.row_i[k*16 +: 16] = row;
    endtask

    task automatic rand_data();
        for (int k = 0; k < NS; k++) begin
            set_scale(k, FPW'($urandom), FPW'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.valid_i  = '0;
        bus.enable_i = 1'b0;
        inject       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_result(input int limit, output bit found, output int at);
        found = 1'b0;
        at    = 0;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (bus.valid_o != '0) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic          en;
        logic [NS-1:0] valid;
        logic [NS-1:0] exp_ready;
    } arb_vec_t;

    arb_vec_t vecs[11];
    bit       found;
    int       at;
    int       start;
    int       cnt;
    bit       done;

    initial begin
        // Pointer starts at NS-1 after reset; each row depends on the previous grant.
        vecs[0]  = '{1'b1, 3'b001, 3'b001};
        vecs[1]  = '{1'b1, 3'b011, 3'b010};
        vecs[2]  = '{1'b1, 3'b011, 3'b001};
        vecs[3]  = '{1'b1, 3'b111, 3'b010};
        vecs[4]  = '{1'b1, 3'b111, 3'b100};
        vecs[5]  = '{1'b1, 3'b100, 3'b100};
        vecs[6]  = '{1'b1, 3'b101, 3'b001};
        vecs[7]  = '{1'b0, 3'b110, 3'b000};
        vecs[8]  = '{1'b1, 3'b110, 3'b010};
        vecs[9]  = '{1'b1, 3'b000, 3'b000};
        vecs[10] = '{1'b1, 3'b101, 3'b100};

        bus.enable_i = 1'b0;
        bus.valid_i  = '0;
        rand_data();
        do_reset();

        @(negedge clk);
        check("reset_valid_o", 128'(bus.valid_o), 128'(0));
        check("reset_z_o", 128'(bus.z_o), 128'(0));
        check("reset_div_valid_o", 128'(bus.div_valid_o), 128'(0));
        check("reset_inflight", 128'(bus.inflight_o), 128'(0));
        check("reset_err", 128'(bus.err_o), 128'(0));
        check("reset_idle", 128'(bus.idle_o), 128'(1));
        check("reset_ready", 128'(bus.ready_o), 128'(0));

        // Scale 1 alone: 4.0 / 2.0
        tick();
        bus.enable_i = 1'b1;
        set_scale(1, 32'h40800000, 32'h40000000, 16'h0011, 16'h0022);
        bus.valid_i = 3'b010;
        start = cyc;
        tick();
        bus.valid_i = '0;
        wait_result(20, found, at);
        check("dir_found", 128'(found), 128'(1));
        check("dir_latency", 128'(at - start), 128'(10));
        check("dir_valid_o", 128'(bus.valid_o), 128'(3'b010));
        check("dir_z_o", 128'(bus.z_o), 128'(32'h40000000));
        repeat (4) tick();

        // Arbitration table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.enable_i = vecs[i].en;
            bus.valid_i  = vecs[i].valid;
            rand_data();
            @(negedge clk);
            check("table_ready", 128'(bus.ready_o), 128'(vecs[i].exp_ready));
            tick();
        end
        bus.valid_i = '0;
        repeat (12) tick();

        // All scales valid: strict rotation
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.enable_i = 1'b1;
            bus.valid_i  = 3'b111;
            rand_data();
            @(negedge clk);
            check("rotation_ready", 128'(bus.ready_o), 128'(3'b001 << (i % 3)));
            tick();
        end
        bus.valid_i = '0;
        repeat (12) tick();

        // Negative W on scale 2
        set_scale(2, 32'h40800000, 32'hC0000000, 16'h0102, 16'h0304);
        bus.valid_i = 3'b100;
        tick();
        bus.valid_i = '0;
        wait_result(20, found, at);
        check("neg_found", 128'(found), 128'(1));
        check("neg_c_o", 128'(bus.c_o), 128'(32'h40000000));
        check("neg_z_o", 128'(bus.z_o), 128'(32'hC0000000));
        check("neg_scale_o", 128'(bus.scale_o), 128'(2));
        check("neg_valid_o", 128'(bus.valid_o), 128'(3'b100));
        repeat (4) tick();

        // Drain with enable low and 5 in flight
        for (int i = 0; i < 5; i++) begin
            bus.enable_i = 1'b1;
            bus.valid_i  = 3'b111;
            rand_data();
            tick();
        end
        bus.enable_i = 1'b0;
        cnt  = 0;
        done = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            check("drain_ready", 128'(bus.ready_o), 128'(0));
            if (bus.valid_o != '0) cnt++;
            if (bus.inflight_o == '0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 128'(done), 128'(1));
        check("drain_count", 128'(cnt), 128'(5));
        check("drain_idle", 128'(bus.idle_o), 128'(1));
        check("drain_inflight", 128'(bus.inflight_o), 128'(0));

        // Spurious divider valid
        tick();
        bus.valid_i = '0;
        @(negedge clk);
        check("err_before", 128'(bus.err_o), 128'(0));
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        check("err_set", 128'(bus.err_o), 128'(1));
        repeat (5) tick();
        @(negedge clk);
        check("err_sticky", 128'(bus.err_o), 128'(1));
        tick();
        rst_n = 1'b0;
        #1;
        check("err_cleared", 128'(bus.err_o), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // Reset with 6 in flight
        for (int i = 0; i < 6; i++) begin
            bus.enable_i = 1'b1;
            bus.valid_i  = 3'b111;
            rand_data();
            tick();
        end
        bus.valid_i  = '0;
        bus.enable_i = 1'b0;
        check("mid_inflight_pre", 128'(bus.inflight_o), 128'(6));
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid_o", 128'(bus.valid_o), 128'(0));
        check("mid_outputs", 128'({bus.z_o, bus.c_o, bus.col_o, bus.row_o, bus.scale_o}), 128'(0));
        check("mid_inflight", 128'(bus.inflight_o), 128'(0));
        check("mid_div_valid_o", 128'(bus.div_valid_o), 128'(0));
        check("mid_div_v_o", 128'(bus.div_v_o), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (bus.valid_o != '0) cnt++;
        end
        check("mid_no_valid_after", 128'(cnt), 128'(0));

        // Random traffic
        tick();
        for (int i = 0; i < 400; i++) begin
            bus.enable_i = ($urandom_range(0, 9) != 0);
            bus.valid_i  = NS'($urandom_range(0, 7));
            rand_data();
            tick();
        end
        bus.valid_i = '0;
        repeat (15) tick();
        check("final_queue_empty", 128'(exp_q.size()), 128'(0));
        check("final_err", 128'(bus.err_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
